// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue
//   Prefetch queue between the instruction memory port and the decoder.
//   Issues sequential word-aligned fetch requests under a credit limit of
//   DEPTH (queued entries plus requests in flight). It buffers in-order
//   responses tagged with their PC and presents the head entry to decode
//   through a valid/ready handshake. A flush redirects the fetch stream and
//   discards every response still owed to the stale stream.
//
// Optional feature: FETCH_QUEUE_BYPASS_EN. When it is defined, a response
//   that arrives while the queue is empty (nothing to drop, no flush) is
//   presented to decode in the same cycle. If decode takes it, the response
//   is not written into the queue.
//
// Ports
//   clk, reset                   clock, async active-low reset
//   mem_req_valid/_address/_ready  fetch request channel (out/out/in)
//   mem_rsp_valid/_data          in-order fetch response (in)
//   flush, flush_address         redirect request and new PC (in)
//   instruction/_pc/_valid       head entry toward decode (out)
//   decode_ready                 decode consumes head on valid&ready (in)
`timescale 1ns/1ps
module instruction_fetch_queue #(
  parameter int unsigned DEPTH         = 4,
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_address,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        flush,
  input  logic [31:0] flush_address,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        instruction_valid,
  input  logic        decode_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic              started_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       rsp_pc_q, rsp_pc_d;
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       pc_q   [DEPTH];

  logic        credit_ok;
  logic        req_fire;
  logic        queue_empty;
  logic        drop_active;
  logic        rsp_keep;
  logic        bypass;
  logic        push;
  logic        pop;
  logic [31:0] flush_pc;
  logic        unused_flush_lsb;

  // The low address bits of a redirect are ignored: fetches are word aligned.
  assign flush_pc         = {flush_address[31:2], 2'b00};
  assign unused_flush_lsb = ^flush_address[1:0];

  // Request credit: entries held plus requests still owed a response.
  assign credit_ok       = (SUM_W'(count_q) + SUM_W'(outstanding_q)) < SUM_W'(DEPTH);
  assign mem_req_valid   = started_q && !flush && credit_ok;
  assign mem_req_address = fetch_pc_q;
  assign req_fire        = mem_req_valid && mem_req_ready;

  assign queue_empty = (count_q == '0);
  assign drop_active = (drop_q != '0);
  assign rsp_keep    = mem_rsp_valid && !drop_active && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = rsp_keep && queue_empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed response that decode takes immediately never enters storage.
  assign pop  = !queue_empty && decode_ready && !flush;
  assign push = rsp_keep && !(bypass && decode_ready);

  // Head presentation; NOP/PC 0 whenever nothing is valid.
  always_comb begin
    instruction       = NOP;
    instruction_pc    = 32'h0;
    instruction_valid = 1'b0;
    if (!queue_empty) begin
      instruction       = data_q[rd_ptr_q];
      instruction_pc    = pc_q[rd_ptr_q];
      instruction_valid = 1'b1;
    end else if (bypass) begin
      instruction       = mem_rsp_data;
      instruction_pc    = rsp_pc_q;
      instruction_valid = 1'b1;
    end
  end

  // Next-state for fetch stream, response tracking and queue pointers.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(mem_rsp_valid);
    drop_d        = drop_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (flush) begin
      // Every response still owed after this cycle belongs to the stale stream.
      fetch_pc_d = flush_pc;
      rsp_pc_d   = flush_pc;
      drop_d     = outstanding_q - CNT_W'(mem_rsp_valid);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (mem_rsp_valid && drop_active) begin
        drop_d = drop_q - CNT_W'(1);
      end
      if (rsp_keep) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      fetch_pc_q    <= RESET_ADDRESS;
      rsp_pc_q      <= RESET_ADDRESS;
    end else begin
      started_q     <= 1'b1;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
    end
  end

  // Entry storage; contents are qualified by count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= mem_rsp_data;
      pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

`ifndef SYNTHESIS
  // Credit accounting must never allow overflow or underflow of the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (push && !flush && (count_q == CNT_W'(DEPTH)) && !pop)
        $error("instruction_fetch_queue: push into full queue");
      if (pop && queue_empty)
        $error("instruction_fetch_queue: pop from empty queue");
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
`timescale 1ns/1ps
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic [31:0] mem_req_address;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        flush;
  logic [31:0] flush_address;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic        instruction_valid;
  logic        decode_ready;

  int total = 0;
  int bad   = 0;

  logic [31:0] rsp_words [4];

  instruction_fetch_queue #(.DEPTH(4), .RESET_ADDRESS(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_req_valid    (mem_req_valid),
    .mem_req_address  (mem_req_address),
    .mem_req_ready    (mem_req_ready),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data),
    .flush            (flush),
    .flush_address    (flush_address),
    .instruction      (instruction),
    .instruction_pc   (instruction_pc),
    .instruction_valid(instruction_valid),
    .decode_ready     (decode_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%0h exp=0", mem_req_valid); end
    total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid got=%0h exp=0", instruction_valid); end
    total++; if (instruction !== 32'h13) begin bad++; $display("FAIL rst_nop got=%h exp=00000013", instruction); end
    total++; if (instruction_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=00000000", instruction_pc); end
  endtask

  task automatic test_fetch_credit();
    step(); reset = 1'b1; mem_req_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (mem_req_valid !== 1'b1 || mem_req_address !== 32'(4 * i))
        begin bad++; $display("FAIL req_seq%0d got=%0h/%h exp=1/%h", i, mem_req_valid, mem_req_address, 32'(4 * i)); end
    end
    @(negedge clk);
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL credit_out got=%0h exp=0", mem_req_valid); end
  endtask

  task automatic test_full_and_pop();
    for (int i = 0; i < 4; i++) begin
      step(); mem_rsp_valid = 1'b1; mem_rsp_data = rsp_words[i];
      @(negedge clk);
      total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL full_req%0d got=%0h exp=0", i, mem_req_valid); end
    end
    step(); mem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL full_hold got=%0h exp=0", mem_req_valid); end
    total++; if (instruction_valid !== 1'b1 || instruction !== rsp_words[0] || instruction_pc !== 32'h0)
      begin bad++; $display("FAIL head0 got=%0h/%h/%h exp=1/%h/00000000", instruction_valid, instruction, instruction_pc, rsp_words[0]); end
    step(); decode_ready = 1'b1;
    step(); decode_ready = 1'b0;
    @(negedge clk);
    total++; if (mem_req_valid !== 1'b1 || mem_req_address !== 32'h10)
      begin bad++; $display("FAIL req_after_pop got=%0h/%h exp=1/00000010", mem_req_valid, mem_req_address); end
    total++; if (instruction !== rsp_words[1] || instruction_pc !== 32'h4)
      begin bad++; $display("FAIL head1 got=%h/%h exp=%h/00000004", instruction, instruction_pc, rsp_words[1]); end
  endtask

  task automatic test_flush_drop();
    step(); decode_ready = 1'b1;
    step(); decode_ready = 1'b0;
    step(); flush = 1'b1; flush_address = 32'h0000_0103;
    @(negedge clk);
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL flush_req got=%0h exp=0", mem_req_valid); end
    step(); flush = 1'b0;
    @(negedge clk);
    total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%0h exp=0", instruction_valid); end
    total++; if (mem_req_valid !== 1'b1 || mem_req_address !== 32'h100)
      begin bad++; $display("FAIL flush_restart got=%0h/%h exp=1/00000100", mem_req_valid, mem_req_address); end
    step(); mem_req_ready = 1'b0;
    step(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_0001;
    step(); mem_rsp_data = 32'hDEAD_0002;
    @(negedge clk);
    total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL stale1_dropped got=%0h exp=0", instruction_valid); end
    step(); mem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL stale2_dropped got=%0h exp=0", instruction_valid); end
    step(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0010_0113;
    step(); mem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if (instruction_valid !== 1'b1 || instruction !== 32'h0010_0113 || instruction_pc !== 32'h100)
      begin bad++; $display("FAIL flush_first got=%0h/%h/%h exp=1/00100113/00000100", instruction_valid, instruction, instruction_pc); end
    step(); decode_ready = 1'b1;
    step(); decode_ready = 1'b0;
  endtask

  task automatic test_flush_same_cycle();
    step(); mem_req_ready = 1'b1;
    step();
    step();
    step(); mem_req_ready = 1'b0;
    step(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_1111;
    step(); mem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if (instruction_valid !== 1'b1 || instruction_pc !== 32'h104)
      begin bad++; $display("FAIL pre_flush_head got=%0h/%h exp=1/00000104", instruction_valid, instruction_pc); end
    step(); flush = 1'b1; flush_address = 32'h200; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h2222_2222; decode_ready = 1'b1;
    step(); flush = 1'b0; mem_rsp_valid = 1'b0; decode_ready = 1'b0;
    @(negedge clk);
    total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL fsc_empty got=%0h exp=0", instruction_valid); end
    total++; if (mem_req_valid !== 1'b1 || mem_req_address !== 32'h200)
      begin bad++; $display("FAIL fsc_restart got=%0h/%h exp=1/00000200", mem_req_valid, mem_req_address); end
    step(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h3333_3333;
    @(negedge clk);
    total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL fsc_drop_now got=%0h exp=0", instruction_valid); end
    step(); mem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL fsc_dropped got=%0h exp=0", instruction_valid); end
    step(); mem_req_ready = 1'b1;
    step(); mem_req_ready = 1'b0;
    step(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0020_0113;
    step(); mem_rsp_valid = 1'b0;
    @(negedge clk);
    total++; if (instruction_valid !== 1'b1 || instruction !== 32'h0020_0113 || instruction_pc !== 32'h200)
      begin bad++; $display("FAIL fsc_one_drop got=%0h/%h/%h exp=1/00200113/00000200", instruction_valid, instruction, instruction_pc); end
    step(); decode_ready = 1'b1;
    step(); decode_ready = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    step(); mem_req_ready = 1'b1;
    step();
    step();
    step(); mem_req_ready = 1'b0;
    step(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA000_0001;
    step(); mem_rsp_data = 32'hA000_0002;
    step(); mem_rsp_data = 32'hA000_0003;
    step(); mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    total++; if (instruction_valid !== 1'b1 || instruction_pc !== 32'h204 || mem_req_valid !== 1'b1)
      begin bad++; $display("FAIL pre_reset got=%0h/%h/%0h exp=1/00000204/1", instruction_valid, instruction_pc, mem_req_valid); end
    #1 reset = 1'b0;
    #1;
    total++; if (instruction_valid !== 1'b0 || mem_req_valid !== 1'b0)
      begin bad++; $display("FAIL async_reset got=%0h/%0h exp=0/0", instruction_valid, mem_req_valid); end
    step(); reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (mem_req_valid !== 1'b1 || mem_req_address !== 32'h0 || instruction_valid !== 1'b0)
      begin bad++; $display("FAIL reset_restart got=%0h/%h/%0h exp=1/00000000/0", mem_req_valid, mem_req_address, instruction_valid); end
  endtask

  task automatic test_bypass_latency();
    step(); mem_req_ready = 1'b0; reset = 1'b0;
    step(); reset = 1'b1;
    step();
    step(); mem_req_ready = 1'b1;
    step(); mem_req_ready = 1'b0;
    step(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013; decode_ready = 1'b1;
    @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
    total++; if (instruction_valid !== 1'b1 || instruction_pc !== 32'h0)
      begin bad++; $display("FAIL byp_same got=%0h/%h exp=1/00000000", instruction_valid, instruction_pc); end
`else
    total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL nobyp_same got=%0h exp=0", instruction_valid); end
`endif
    step(); mem_rsp_valid = 1'b0;
    @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
    total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL byp_not_queued got=%0h exp=0", instruction_valid); end
`else
    total++; if (instruction_valid !== 1'b1 || instruction !== 32'h13 || instruction_pc !== 32'h0)
      begin bad++; $display("FAIL nobyp_next got=%0h/%h/%h exp=1/00000013/00000000", instruction_valid, instruction, instruction_pc); end
`endif
    step(); decode_ready = 1'b0;
    @(negedge clk);
    total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL byp_drained got=%0h exp=0", instruction_valid); end
  endtask

  initial begin
    rsp_words[0] = 32'h0050_0093;
    rsp_words[1] = 32'h0060_0113;
    rsp_words[2] = 32'h0070_0193;
    rsp_words[3] = 32'h0080_0213;
    reset         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    flush         = 1'b0;
    flush_address = 32'h0;
    decode_ready  = 1'b0;

    test_reset();
    test_fetch_credit();
    test_full_and_pop();
    test_flush_drop();
    test_flush_same_cycle();
    test_reset_mid_stream();
    test_bypass_latency();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
